hex_scan_ctrl: RTL

- Time-multiplexed scan controller for a bank of 7-segment digits.
- Captures a 4*NUM_DIGITS-bit result word (e.g. an FP32 result, 8 nibbles) and presents one nibble at a time on o_hex_data, which feeds the downstream nibble-to-segment decoder.
- Drives a one-hot digit-enable bus in step with the nibble.
- Double-buffers the word so the display only changes on a scan-frame boundary, which avoids tearing. Optional leading-zero blanking.

---
 rtl/hex_scan_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hex_scan_ctrl.sv
// Scan controller for a bank of 7-segment digits: shows one nibble per slot, with a
// one-hot digit enable and optional leading-zero blanking. Words are double-buffered to frame boundaries.
module hex_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int TYPE_ANODE  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic                    i_blank_lz,
    output logic [3:0]              o_hex_data,
    output logic [NUM_DIGITS-1:0]   o_digit_sel,
    output logic                    o_blank,
    output logic                    o_pending
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int WW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF =
        (TYPE_ANODE != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WW-1:0]         pend_q, pend_d;
    logic [WW-1:0]         disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d;

    logic tick;
    logic frame;
    logic slot_blank;

    assign tick  = (div_q == DIV_LAST);
    assign frame = tick && (idx_q == IDX_LAST);

    assign div_d     = tick ? '0 : div_q + DW'(1);
    assign idx_d     = !tick ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + IW'(1));
    // A strobe coinciding with a transfer still lands in pend_q and keeps pending set.
    assign disp_d    = (frame && pending_q) ? pend_q : disp_q;
    assign pend_d    = i_valid ? i_data : pend_q;
    assign pending_d = i_valid || (pending_q && !frame);

    // Slot views of the word about to be displayed; zero_above[k] means nibbles k..top are zero.
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS:1]   zero_above;
    logic [NUM_DIGITS-1:0] lz;

    assign zero_above[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        assign nib[gi] = disp_d[4*gi +: 4];
        if (gi == 0) begin : g_first
            assign lz[gi] = 1'b0;
        end else begin : g_upper
            assign zero_above[gi] = (nib[gi] == 4'd0) && zero_above[gi+1];
            assign lz[gi]         = zero_above[gi];
        end
    end

    always_comb begin
        hex_d      = hex_q;
        sel_d      = sel_q;
        blank_d    = blank_q;
        slot_blank = i_blank_lz && lz[idx_d];
        if (tick) begin
            blank_d = slot_blank;
            hex_d   = slot_blank ? 4'd0 : nib[idx_d];
            sel_d   = slot_blank ? SEL_OFF : ((ONE << idx_d) ^ SEL_OFF);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            hex_q     <= 4'd0;
            sel_q     <= SEL_OFF;
            blank_q   <= 1'b1;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            sel_q     <= sel_d;
            blank_q   <= blank_d;
        end
    end

    assign o_hex_data  = hex_q;
    assign o_digit_sel = sel_q;
    assign o_blank     = blank_q;
    assign o_pending   = pending_q;
endmodule
